// File: rtl/fft_out_collector.sv
// Collects one dual-lane FFT frame into a ping-pong bank and replays it one sample per cycle.
// FFT_OUT_BITREV_EN defined: bit-reversed write addressing (natural order out); undefined: stream order out.
//
// state  | meaning
// C_IDLE | waiting for in_start
// C_CAP  | writing pairs 1..N/2-1 into bank[wbank]
// C_DROP | both banks busy, counting out a discarded frame
// D_IDLE | waiting for full[rbank]; loads entry 0 when it is set
// D_RUN  | presenting entries 0..N-1 over valid/ready
module fft_out_collector #(
  parameter int DW   = 16,
  parameter int LOGN = 6
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_start,
  input  logic [DW-1:0]   in_re0,
  input  logic [DW-1:0]   in_im0,
  input  logic [DW-1:0]   in_re1,
  input  logic [DW-1:0]   in_im1,
  output logic [DW-1:0]   dout_re,
  output logic [DW-1:0]   dout_im,
  output logic [LOGN-1:0] dout_idx,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            overflow
);

  localparam int N = 2 ** LOGN;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CAP  = 2'd1;
  localparam logic [1:0] C_DROP = 2'd2;
  localparam logic       D_IDLE = 1'b0;
  localparam logic       D_RUN  = 1'b1;

  localparam logic [LOGN-2:0] PC_ONE   = {{(LOGN-2){1'b0}}, 1'b1};
  localparam logic [LOGN-2:0] PC_LAST  = '1;
  localparam logic [LOGN-1:0] RC_ONE   = {{(LOGN-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] IDX_ZERO = '0;
  localparam logic [LOGN-1:0] IDX_LAST = '1;

  logic [1:0]      r_cstate;
  logic [LOGN-2:0] r_pc;
  logic            r_wbank;
  logic [1:0]      r_full;
  logic            r_overflow;

  logic            r_dstate;
  logic [LOGN-1:0] r_rc;
  logic            r_rbank;
  logic [DW-1:0]   r_dout_re;
  logic [DW-1:0]   r_dout_im;
  logic [LOGN-1:0] r_dout_idx;
  logic            r_dout_valid;
  logic            r_dout_last;

  logic [DW-1:0]   r_mem_re [2][N];
  logic [DW-1:0]   r_mem_im [2][N];

  logic [LOGN-2:0] w_pair;
  logic [LOGN-1:0] w_pos0;
  logic [LOGN-1:0] w_pos1;
  logic [LOGN-1:0] w_addr0;
  logic [LOGN-1:0] w_addr1;
  logic            w_wr_en;
  logic            w_cap_done;
  logic            w_xfer;
  logic            w_drain_done;
  logic [1:0]      w_set;
  logic [1:0]      w_clr;

`ifdef FFT_OUT_BITREV_EN
  function automatic logic [LOGN-1:0] f_bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction
`endif

  // Pair 0 is written on the in_start cycle itself, before r_pc has advanced.
  assign w_pair = (r_cstate == C_IDLE) ? '0 : r_pc;
  assign w_pos0 = {w_pair, 1'b0};
  assign w_pos1 = {w_pair, 1'b1};

`ifdef FFT_OUT_BITREV_EN
  assign w_addr0 = f_bitrev(w_pos0);
  assign w_addr1 = f_bitrev(w_pos1);
`else
  assign w_addr0 = w_pos0;
  assign w_addr1 = w_pos1;
`endif

  assign w_wr_en      = nrst && (((r_cstate == C_IDLE) && in_start && !r_full[r_wbank]) ||
                                 (r_cstate == C_CAP));
  assign w_cap_done   = (r_cstate == C_CAP) && (r_pc == PC_LAST);
  assign w_xfer       = (r_dstate == D_RUN) && r_dout_valid && dout_ready;
  assign w_drain_done = w_xfer && (r_dout_idx == IDX_LAST);
  assign w_set        = w_cap_done   ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr        = w_drain_done ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[r_wbank][w_addr0] <= in_re0;
      r_mem_im[r_wbank][w_addr0] <= in_im0;
      r_mem_re[r_wbank][w_addr1] <= in_re1;
      r_mem_im[r_wbank][w_addr1] <= in_im1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cstate   <= C_IDLE;
      r_pc       <= '0;
      r_wbank    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_cstate)
        C_IDLE: begin
          if (in_start) begin
            r_pc <= PC_ONE;
            if (r_full[r_wbank]) begin
              r_overflow <= 1'b1;
              r_cstate   <= C_DROP;
            end else begin
              r_cstate <= C_CAP;
            end
          end
        end
        C_CAP: begin
          r_pc <= r_pc + PC_ONE;
          if (r_pc == PC_LAST) begin
            r_wbank  <= ~r_wbank;
            r_cstate <= C_IDLE;
          end
        end
        C_DROP: begin
          r_pc <= r_pc + PC_ONE;
          if (r_pc == PC_LAST) r_cstate <= C_IDLE;
        end
        default: begin
          r_cstate <= C_IDLE;
          r_pc     <= '0;
        end
      endcase
    end
  end

  // Set and clear always target different banks, so both may apply on one edge.
  always_ff @(posedge clk) begin
    if (!nrst) r_full <= 2'b00;
    else       r_full <= (r_full & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_dstate     <= D_IDLE;
      r_rc         <= '0;
      r_rbank      <= 1'b0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_dout_idx   <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else if (r_dstate == D_IDLE) begin
      if (r_full[r_rbank]) begin
        r_dout_re    <= r_mem_re[r_rbank][IDX_ZERO];
        r_dout_im    <= r_mem_im[r_rbank][IDX_ZERO];
        r_dout_idx   <= IDX_ZERO;
        r_dout_valid <= 1'b1;
        r_dout_last  <= 1'b0;
        r_rc         <= RC_ONE;
        r_dstate     <= D_RUN;
      end
    end else if (w_xfer) begin
      if (w_drain_done) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
        r_rbank      <= ~r_rbank;
        r_rc         <= '0;
        r_dstate     <= D_IDLE;
      end else begin
        r_dout_re   <= r_mem_re[r_rbank][r_rc];
        r_dout_im   <= r_mem_im[r_rbank][r_rc];
        r_dout_idx  <= r_rc;
        r_dout_last <= (r_rc == IDX_LAST);
        r_rc        <= r_rc + RC_ONE;
      end
    end
  end

  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;
  assign dout_idx   = r_dout_idx;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed bench for fft_out_collector: expected samples come from a queue filled per accepted frame.
// Expected ordering follows FFT_OUT_BITREV_EN the same way the design build does.
module tb_fft_out_collector;

  logic        clk;
  logic        nrst;
  logic        in_start;
  logic [15:0] in_re0, in_im0, in_re1, in_im1;
  logic [15:0] dout_re, dout_im;
  logic [5:0]  dout_idx;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        overflow;

  fft_out_collector #(.DW(16), .LOGN(6)) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_start   (in_start),
    .in_re0     (in_re0),
    .in_im0     (in_im0),
    .in_re1     (in_re1),
    .in_im1     (in_im1),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .overflow   (overflow)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  int          cyc      = 0;
  int          ts;
  int          x0;
  logic        stall_pend = 1'b0;
  logic [15:0] s_re, s_im;
  logic [5:0]  s_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] brev6(input logic [5:0] x);
    return {x[0], x[1], x[2], x[3], x[4], x[5]};
  endfunction

  task automatic push_frame(input int tag);
    logic [5:0]  ii;
    logic [15:0] v;
    for (int i = 0; i < 64; i++) begin
      ii = 6'(i);
`ifdef FFT_OUT_BITREV_EN
      v = 16'(tag * 64) + {10'd0, brev6(ii)};
`else
      v = 16'(tag * 64) + {10'd0, ii};
`endif
      q.push_back('{v, ~v + 16'd1, ii});
    end
  endtask

  // Lane data: re = tag*64 + stream position, im = -re.
  task automatic send_frame(input int tag, input int restart);
    logic [15:0] a;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      a        = 16'(tag * 64 + 2 * k);
      in_start = (k == 0) || (k == restart);
      in_re0   = a;
      in_im0   = ~a + 16'd1;
      in_re1   = a + 16'd1;
      in_im1   = ~(a + 16'd1) + 16'd1;
    end
  endtask

  task automatic end_stream();
    @(posedge clk); #1;
    in_start = 1'b0;
    in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
  endtask

  task automatic at_edge(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_valid"},    32'(dout_valid), 32'd0);
    check({pfx, "_last"},     32'(dout_last),  32'd0);
    check({pfx, "_idx"},      32'(dout_idx),   32'd0);
    check({pfx, "_re"},       32'(dout_re),    32'd0);
    check({pfx, "_im"},       32'(dout_im),    32'd0);
    check({pfx, "_overflow"}, 32'(overflow),   32'd0);
  endtask

  // Output monitor: every transfer is matched against the queue; stalled outputs must hold.
  always @(negedge clk) begin
    if (nrst && dout_valid) begin
      if (stall_pend) begin
        check("hold_re",  32'(dout_re),  32'(s_re));
        check("hold_im",  32'(dout_im),  32'(s_im));
        check("hold_idx", 32'(dout_idx), 32'(s_idx));
      end
      if (dout_ready) begin
        stall_pend = 1'b0;
        n_xfer++;
        if (q.size() == 0) begin
          check("pending_expected", 32'(q.size()), 32'd1);
        end else begin
          m_e = q.pop_front();
          check("out_idx",  32'(dout_idx),  32'(m_e.idx));
          check("out_re",   32'(dout_re),   32'(m_e.re));
          check("out_im",   32'(dout_im),   32'(m_e.im));
          check("out_last", 32'(dout_last), 32'(m_e.idx == 6'd63));
        end
      end else begin
        stall_pend = 1'b1;
        s_re  = dout_re;
        s_im  = dout_im;
        s_idx = dout_idx;
      end
    end else begin
      if (nrst && stall_pend) check("hold_valid", 32'(dout_valid), 32'd1);
      stall_pend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; in_start = 1'b0; dout_ready = 1'b1;
    in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    nrst = 1'b1;

    // Single frame: latency and ordering
    align();
    ts = cyc + 2;
    push_frame(1);
    fork
      begin send_frame(1, -1); end_stream(); end
      begin
        at_edge(ts + 31);
        check("lat_before_valid", 32'(dout_valid), 32'd0);
        at_edge(ts + 32);
        check("lat_first_valid", 32'(dout_valid), 32'd1);
        check("lat_first_idx",   32'(dout_idx),   32'd0);
      end
    join
    wait_drain(200);

    // Backpressure 1,0,0,1
    align();
    x0 = n_xfer;
    push_frame(2);
    fork
      begin send_frame(2, -1); end_stream(); end
      begin
        for (int c = 0; c < 240; c++) begin
          @(posedge clk); #1;
          dout_ready = (c % 4 == 0) || (c % 4 == 3);
        end
      end
    join
    dout_ready = 1'b1;
    wait_drain(200);
    check("bp_transfers", 32'(n_xfer - x0), 32'd64);

    // Two back-to-back frames with a single idle cycle between drains
    align();
    ts = cyc + 2;
    push_frame(3);
    push_frame(4);
    fork
      begin send_frame(3, -1); send_frame(4, -1); end_stream(); end
      begin
        at_edge(ts + 95);
        check("b2b_a_last_idx", 32'(dout_idx), 32'd63);
        at_edge(ts + 96);
        check("b2b_gap_valid", 32'(dout_valid), 32'd0);
        at_edge(ts + 97);
        check("b2b_b_valid", 32'(dout_valid), 32'd1);
        check("b2b_b_idx",   32'(dout_idx),   32'd0);
      end
    join
    wait_drain(200);
    check("b2b_overflow", 32'(overflow), 32'd0);

    // Three frames against a stalled sink: the third is dropped
    align();
    dout_ready = 1'b0;
    push_frame(9);
    push_frame(10);
    send_frame(9, -1);
    send_frame(10, -1);
    send_frame(11, -1);
    end_stream();
    check("drop_overflow",  32'(overflow),   32'd1);
    check("drop_stall_idx", 32'(dout_idx),   32'd0);
    dout_ready = 1'b1;
    wait_drain(300);
    repeat (10) @(negedge clk);
    check("drop_no_third", 32'(dout_valid), 32'd0);
    check("drop_overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-capture at pair 10
    align();
    ts = cyc + 2;
    fork
      begin send_frame(5, -1); end_stream(); end
      begin
        at_edge(ts + 9);
        nrst = 1'b0;
        at_edge(ts + 10);
        check_reset("rst_cap");
        nrst = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    check("rst_cap_no_out", 32'(dout_valid), 32'd0);

    // Reset mid-drain at idx 20
    align();
    ts = cyc + 2;
    push_frame(6);
    fork
      begin send_frame(6, -1); end_stream(); end
      begin
        at_edge(ts + 52);
        check("rst_drain_idx", 32'(dout_idx), 32'd20);
        nrst = 1'b0;
        at_edge(ts + 53);
        check_reset("rst_drain");
        nrst = 1'b1;
        q.delete();
      end
    join
    repeat (10) @(negedge clk);
    check("rst_drain_no_out", 32'(dout_valid), 32'd0);

    // Fresh frame after reset
    align();
    push_frame(7);
    send_frame(7, -1);
    end_stream();
    wait_drain(200);
    check("fresh_overflow", 32'(overflow), 32'd0);

    // Spurious in_start at pair 5 is ignored
    align();
    push_frame(8);
    send_frame(8, 5);
    end_stream();
    wait_drain(200);
    repeat (40) @(negedge clk);
    check("restart_no_extra", 32'(dout_valid), 32'd0);
    check("restart_overflow", 32'(overflow),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
